// File: rtl/rd_readout_sequencer_pkg.sv
`default_nettype none
// rd_readout_sequencer_pkg: shared RD defs (status bit positions, control field, FSM states, result codes).
// Rev 1.0
package rd_readout_sequencer_pkg;

  localparam int RD_FULL_SHIFT   = 0;
  localparam int RD_BUSY_SHIFT   = 4;
  localparam int RD_PAR0_SHIFT   = 8;
  localparam int RD_PAR1_SHIFT   = 12;

  localparam int RD_CTRL_BUF_LSB = 0;
  localparam int RD_CTRL_BUF_MSB = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTLE    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_XFER      = 3'd3;
  localparam logic [2:0] ST_CLEAR     = 3'd4;
  localparam logic [2:0] ST_WAIT_CLR  = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  typedef enum logic [2:0] {
    RES_OK           = 3'd0,
    RES_SKIP_EMPTY   = 3'd1,
    RES_TIMEOUT_BUSY = 3'd2,
    RES_PARITY       = 3'd3,
    RES_CLEAR_FAIL   = 3'd4
  } rd_result_e;

  typedef struct packed {
    logic [3:0] par1;
    logic [3:0] par0;
    logic [3:0] busy;
    logic [3:0] full;
  } rd_status_t;

  function automatic rd_status_t rd_pick_status(input logic [31:0] word);
    rd_status_t s;
    s.full = word[RD_FULL_SHIFT +: 4];
    s.busy = word[RD_BUSY_SHIFT +: 4];
    s.par0 = word[RD_PAR0_SHIFT +: 4];
    s.par1 = word[RD_PAR1_SHIFT +: 4];
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_status_sync.sv
`default_nettype none
// rd_status_sync: 16-bit status synchronizer; reports the current value only once two samples agree.
// Rev 1.0
module rd_status_sync (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] raw_i,
  output logic [15:0] value_o,
  output logic        stable_o
);

  logic [15:0] sync_bits;
  logic [15:0] prev_q;
  logic [15:0] held_q;
  logic        stable;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_bit
      rd_sync_1bit u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (raw_i[i]),
        .q_o   (sync_bits[i])
      );
    end
  endgenerate

  assign stable = (sync_bits == prev_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 16'h0000;
      held_q <= 16'h0000;
    end else begin
      prev_q <= sync_bits;
      if (stable) held_q <= sync_bits;
    end
  end

  // While a bit is toggling, consumers keep seeing the last agreed value.
  assign value_o  = stable ? sync_bits : held_q;
  assign stable_o = stable;

endmodule
`default_nettype wire

// File: rtl/rd_sync_1bit.sv
`default_nettype none
// rd_sync_1bit: two-flop synchronizer for one asynchronous bit.
// Rev 1.0
module rd_sync_1bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/rd_readout_sequencer.sv
`default_nettype none
// rd_readout_sequencer: sequences copy-out and full-flag clear of one RD buffer.
// Rev 1.0
module rd_readout_sequencer #(
  parameter int BUSY_TIMEOUT = 50000,
  parameter int WR_HOLD      = 8,
  parameter int CLR_TIMEOUT  = 256,
  parameter int TO_WIDTH     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] RD_STATUS,
  input  logic        START,
  input  logic [1:0]  BUF_RNUM,
  input  logic        XFR_DONE,
  output logic        XFR_REQ,
  output logic [1:0]  XFR_BUF,
  output logic [31:0] AXI_CONTROL,
  output logic        AXI_CONTROL_WRITTEN,
  output logic        DONE,
  output logic [2:0]  RESULT,
  output logic [1:0]  PARITY_ERR,
  output logic        START_IGNORED,
  output logic        BUSY
);

  import rd_readout_sequencer_pkg::*;

  localparam int                  HOLD_W    = $clog2(WR_HOLD + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(WR_HOLD);
  localparam logic [TO_WIDTH-1:0] BUSY_LOAD = TO_WIDTH'(BUSY_TIMEOUT);
  localparam logic [TO_WIDTH-1:0] CLR_LOAD  = TO_WIDTH'(CLR_TIMEOUT);

  rd_status_t raw_st;
  rd_status_t stat;
  logic [15:0] stat_bits;
  logic        stat_stable;

  logic [2:0]          state_q,   state_d;
  logic [1:0]          lcl_buf_q, lcl_buf_d;
  logic [1:0]          settle_q,  settle_d;
  logic [TO_WIDTH-1:0] timer_q,   timer_d;
  logic [HOLD_W-1:0]   hold_q,    hold_d;
  logic [1:0]          ctrl_q,    ctrl_d;
  logic [1:0]          par_q,     par_d;
  rd_result_e          result_q,  result_d;
  logic [1:0]          parerr_q,  parerr_d;
  logic                ign_q;

  logic                cur_full;
  logic                cur_busy;
  logic [TO_WIDTH-1:0] timer_dec;

  assign raw_st = rd_pick_status(RD_STATUS);

  rd_status_sync u_status_sync (
    .clk_i    (CLK),
    .rst_i    (RST),
    .raw_i    (raw_st),
    .value_o  (stat_bits),
    .stable_o (stat_stable)
  );

  assign stat      = rd_status_t'(stat_bits);
  assign cur_full  = stat.full[lcl_buf_q];
  assign cur_busy  = stat.busy[lcl_buf_q];
  assign timer_dec = (timer_q == '0) ? '0 : timer_q - TO_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    lcl_buf_d = lcl_buf_q;
    settle_d  = settle_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    ctrl_d    = ctrl_q;
    par_d     = par_q;
    result_d  = result_q;
    parerr_d  = parerr_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          lcl_buf_d = BUF_RNUM;
          settle_d  = 2'd0;
          par_d     = 2'b00;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Earliest decision is the third cycle after START, and only on agreeing samples.
        if (settle_q != 2'd2) begin
          settle_d = settle_q + 2'd1;
        end else if (stat_stable) begin
          if (cur_full) begin
            state_d = ST_XFER;
          end else if (cur_busy) begin
            timer_d = BUSY_LOAD;
            state_d = ST_WAIT_BUSY;
          end else begin
            result_d = RES_SKIP_EMPTY;
            parerr_d = 2'b00;
            state_d  = ST_FINISH;
          end
        end
      end
      ST_WAIT_BUSY: begin
        timer_d = timer_dec;
        if (cur_full) begin
          state_d = ST_XFER;
        end else if (!cur_busy) begin
          result_d = RES_SKIP_EMPTY;
          parerr_d = 2'b00;
          state_d  = ST_FINISH;
        end else if (timer_q == '0) begin
          result_d = RES_TIMEOUT_BUSY;
          parerr_d = 2'b00;
          state_d  = ST_FINISH;
        end
      end
      ST_XFER: begin
        if (XFR_DONE) begin
          par_d   = {stat.par1[lcl_buf_q], stat.par0[lcl_buf_q]};
          ctrl_d  = lcl_buf_q;
          hold_d  = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // hold_q==0 is the setup cycle; the strobe covers hold_q 1..WR_HOLD.
        if (hold_q == HOLD_LAST) begin
          timer_d = CLR_LOAD;
          state_d = ST_WAIT_CLR;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_WAIT_CLR: begin
        timer_d = timer_dec;
        if (!cur_full) begin
          result_d = (par_q != 2'b00) ? RES_PARITY : RES_OK;
          parerr_d = par_q;
          state_d  = ST_FINISH;
        end else if (timer_q == '0) begin
          result_d = RES_CLEAR_FAIL;
          parerr_d = par_q;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        ctrl_d  = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      lcl_buf_q <= 2'b00;
      settle_q  <= 2'd0;
      timer_q   <= '0;
      hold_q    <= '0;
      ctrl_q    <= 2'b00;
      par_q     <= 2'b00;
      result_q  <= RES_OK;
      parerr_q  <= 2'b00;
      ign_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcl_buf_q <= lcl_buf_d;
      settle_q  <= settle_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      ctrl_q    <= ctrl_d;
      par_q     <= par_d;
      result_q  <= result_d;
      parerr_q  <= parerr_d;
      ign_q     <= START && (state_q != ST_IDLE);
    end
  end

  assign XFR_REQ             = (state_q == ST_XFER);
  assign XFR_BUF             = XFR_REQ ? lcl_buf_q : 2'b00;
  assign AXI_CONTROL         = {30'd0, ctrl_q};
  assign AXI_CONTROL_WRITTEN = (state_q == ST_CLEAR) && (hold_q != '0);
  assign DONE                = (state_q == ST_FINISH);
  assign RESULT              = result_q;
  assign PARITY_ERR          = parerr_q;
  assign START_IGNORED       = ign_q;
  assign BUSY                = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/rd_readout_sequencer.md
Name: rd_readout_sequencer

Overview:
- Processor-clock-side controller that sequences readout of one RD buffer after the WCD/SSD data for the same buffer number has been transferred.
- Samples RD interface status across the clock boundary and decides per buffer: transfer, wait while RD is still busy, or skip.
- Hands the transfer to the processor-side copy engine, then clears the buffer-full flag through the RD control register write path.
- Sits between the trigger/readout engine and the RD interface control/status registers.

Parameters:
- BUSY_TIMEOUT, 50000, max CLK cycles to wait for a busy buffer to become full.
- WR_HOLD, 8, CLK cycles AXI_CONTROL_WRITTEN is held high; must be at least 3 serial-clock periods.
- CLR_TIMEOUT, 256, max CLK cycles to wait for the full flag to drop after a clear.
- TO_WIDTH, 16, width of the timeout counter.

Ports:
- CLK  in  1  processor-side clock
- RST  in  1  synchronous reset, active high
- RD_STATUS  in  32  RD interface status word; asynchronous, serial-clock domain
- START  in  1  one-cycle pulse: begin readout of buffer BUF_RNUM
- BUF_RNUM  in  2  buffer number, sampled on START
- XFR_DONE  in  1  one-cycle pulse from copy engine: RD data copied
- XFR_REQ  out  1  level: RD buffer LCL_BUF is full, copy engine may read it
- XFR_BUF  out  2  buffer number for the copy engine
- AXI_CONTROL  out  32  control word to RD interface; buffer number in [1:0], other bits 0
- AXI_CONTROL_WRITTEN  out  1  clear strobe to RD interface
- DONE  out  1  one-cycle pulse: sequence finished
- RESULT  out  3  result code, valid when DONE=1, held until next DONE
- PARITY_ERR  out  2  parity0/parity1 flags for the finished buffer, valid with DONE
- START_IGNORED  out  1  one-cycle pulse: START arrived while not IDLE
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Any RST cycle mid-sequence returns to IDLE next cycle; the clear strobe and XFR_REQ drop immediately, with no DONE.
- Status sync: only FULL[3:0], BUSY[3:0], PAR0[3:0] and PAR1[3:0] (bit positions from the defs include) pass through two flops. A value is "stable" when two consecutive synced samples are equal. Decisions use stable values only.
- IDLE:
  - On START, latch BUF_RNUM into LCL_BUF and go to SETTLE.
  - START in any other state pulses START_IGNORED and is otherwise dropped.
- SETTLE: wait for stable status (minimum 3 cycles after START). Then:
  - full → XFER
  - busy → WAIT_BUSY, load timer with BUSY_TIMEOUT
  - neither → FINISH, RESULT=SKIP_EMPTY
- WAIT_BUSY: timer decrements each cycle. Evaluated in priority order each cycle:
  - full → XFER
  - not busy and not full → FINISH, SKIP_EMPTY
  - timer==0 → FINISH, TIMEOUT_BUSY
  - A full and timer==0 coincidence resolves to XFER.
- XFER: XFR_REQ=1, XFR_BUF=LCL_BUF. Wait indefinitely for XFR_DONE. XFR_DONE in the same cycle as entry is accepted. Latch PAR0/PAR1[LCL_BUF] on exit. Then go to CLEAR.
- CLEAR:
  - AXI_CONTROL[1:0]=LCL_BUF, set one cycle before the strobe and held through WAIT_CLR.
  - AXI_CONTROL_WRITTEN=1 for exactly WR_HOLD cycles.
  - Then go to WAIT_CLR, load timer with CLR_TIMEOUT.
- WAIT_CLR:
  - stable FULL[LCL_BUF]==0 → FINISH, RESULT=OK, or PARITY if either latched parity bit is set.
  - timer==0 → FINISH, CLEAR_FAIL.
- FINISH: DONE=1 for one cycle, RESULT and PARITY_ERR updated, then IDLE. A START coinciding with FINISH is ignored.
- RESULT codes: OK=0, SKIP_EMPTY=1, TIMEOUT_BUSY=2, PARITY=3, CLEAR_FAIL=4. PARITY_ERR is 0 for SKIP_EMPTY and TIMEOUT_BUSY.
- Timer: TO_WIDTH bits, saturates at 0, never wraps.

Decomposition:
- Add to the shared RD defs include: state encodings, RESULT codes, control buffer-number field position [1:0].
- Status-bit shift constants are reused unchanged.
- One sub-module: rd_status_sync. It is a 16-bit two-flop synchronizer plus stability compare and reuses rd_sync_1bit per bit.

Test Plan:
- Full buffer: FULL[2]=1 stable, START with BUF_RNUM=2 → XFR_REQ=1, XFR_BUF=2; after XFR_DONE, AXI_CONTROL[1:0]=2 and WRITTEN high 8 cycles; drop FULL[2] → DONE, RESULT=0.
- Busy then full: BUSY[1]=1, FULL[1] set 1000 cycles after START → XFR_REQ asserted with no timeout; complete → RESULT=0.
- Busy timeout: BUSY=4'b0001 held, BUSY_TIMEOUT=100, START buf 0 → DONE about 100 cycles after WAIT_BUSY entry, RESULT=2, WRITTEN never asserted.
- Empty buffer: status all 0, START buf 3 → DONE within 5 cycles, RESULT=1, XFR_REQ never high.
- Parity and clear failure: FULL[0]=1, PAR1[0]=1 with FULL dropping after clear → RESULT=3, PARITY_ERR=2'b10. Repeat with FULL never dropping → RESULT=4 after CLR_TIMEOUT.
- Robustness: second START during XFER → START_IGNORED pulse, sequence unaffected. RST asserted during CLEAR → WRITTEN=0 the next cycle, BUSY=0, no DONE.
